// File: rtl/mesh_bridge_pkg.sv
// Shared constants and helpers for the mesh terminal bridge:
// header field offsets, broadcast ID, terminal count and terminal IDs.
package mesh_bridge_pkg;

   localparam logic [7:0] BDCST_DEF = 8'hFF;
   localparam int         DEST_W    = 8;

   function automatic int n_term(int rows, int cols);
      return 2 * (rows + cols);
   endfunction

   // MSB of the {row,col} destination field
   function automatic int dest_msb(int ps);
      return ps - 9;
   endfunction

   // Boundary terminals: top row, bottom row, left col, right col
   function automatic logic [7:0] term_id(int t, int rows, int cols);
      int r;
      int c;
      if (t < cols) begin
         r = 0;
         c = t + 1;
      end else if (t < 2 * cols) begin
         r = rows + 1;
         c = t - cols + 1;
      end else if (t < 2 * cols + rows) begin
         r = t - 2 * cols + 1;
         c = 0;
      end else begin
         r = t - 2 * cols - rows + 1;
         c = cols + 1;
      end
      return {r[3:0], c[3:0]};
   endfunction

endpackage

// File: rtl/term_fifo.sv
// Synchronous show-ahead FIFO, count-based full/empty.
// Ports: push/pop strobes, wdata in, head rdata out, full/empty flags.
module term_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_pop;
   logic          do_push;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign do_pop  = pop_i && !empty_o;
   // a pop frees the slot, so a push into a full FIFO is taken
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/mesh_term_bridge.sv
// Bridge between host agents and the mesh router boundary terminals.
// Ports: host inject (wr/data/full), router inject (pndng/data/popin),
// router eject (pndng/data/pop), merged eject stream (valid/ready/data/term),
// traffic counters and sticky overflow / misroute flags.
module mesh_term_bridge
   import mesh_bridge_pkg::*;
#(
   parameter int         ROWS       = 4,
   parameter int         COLUMNS    = 4,
   parameter int         PAKG_SIZE  = 32,
   parameter int         FIFO_DEPTH = 16,
   parameter int         EJ_DEPTH   = 4,
   parameter logic [7:0] BDCST      = BDCST_DEF,
   localparam int        N_TERM     = n_term(ROWS, COLUMNS),
   localparam int        TW         = $clog2(N_TERM)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          clr_i,
   input  logic [N_TERM-1:0]             host_wr_i,
   input  logic [N_TERM*PAKG_SIZE-1:0]   host_data_i,
   output logic [N_TERM-1:0]             host_full_o,
   output logic [N_TERM-1:0]             pndng_i_in_o,
   output logic [N_TERM*PAKG_SIZE-1:0]   data_out_i_in_o,
   input  logic [N_TERM-1:0]             popin_i,
   input  logic [N_TERM-1:0]             pndng_i,
   input  logic [N_TERM*PAKG_SIZE-1:0]   data_out_i,
   output logic [N_TERM-1:0]             pop_o,
   output logic                          ej_valid_o,
   input  logic                          ej_ready_i,
   output logic [PAKG_SIZE-1:0]          ej_data_o,
   output logic [TW-1:0]                 ej_term_o,
   output logic [31:0]                   inj_cnt_o,
   output logic [31:0]                   ej_cnt_o,
   output logic [N_TERM-1:0]             err_ovf_o,
   output logic [N_TERM-1:0]             err_misroute_o
);
   localparam int PS = PAKG_SIZE;
   localparam int DM = dest_msb(PAKG_SIZE);

   logic [N_TERM-1:0] inj_empty;
   logic [N_TERM-1:0] ej_full;
   logic [N_TERM-1:0] ej_empty;
   logic [N_TERM-1:0] ej_pop;
   logic [N_TERM-1:0] mis_hit;
   logic [N_TERM-1:0] ovf_set;
   logic [N_TERM-1:0] hold_q;
   logic [N_TERM-1:0] err_ovf_q;
   logic [N_TERM-1:0] err_mis_q;
   logic [PS-1:0]     ej_rd [N_TERM];
   logic              run_q;
   logic [31:0]       inj_cnt_q;
   logic [31:0]       ej_cnt_q;
   logic [31:0]       inj_inc;
   logic              ej_valid_q;
   logic [PS-1:0]     ej_data_q;
   logic [TW-1:0]     ej_term_q;
   logic [TW-1:0]     rr_q;
   logic [TW-1:0]     gnt;
   logic              gnt_v;
   logic              load;

   for (genvar t = 0; t < N_TERM; t++) begin : g_term
      logic [DEST_W-1:0] dest;

      term_fifo #(.W(PS), .DEPTH(FIFO_DEPTH)) u_inj (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (host_wr_i[t]),
         .pop_i   (popin_i[t]),
         .wdata_i (host_data_i[t*PS +: PS]),
         .rdata_o (data_out_i_in_o[t*PS +: PS]),
         .full_o  (host_full_o[t]),
         .empty_o (inj_empty[t])
      );

      assign pndng_i_in_o[t] = !inj_empty[t];

      // run_q keeps pop low for the first cycle after reset release;
      // hold_q masks the router's stale pending right after a pop
      assign pop_o[t] = run_q && pndng_i[t] && !ej_full[t] && !hold_q[t];

      term_fifo #(.W(PS), .DEPTH(EJ_DEPTH)) u_ej (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (pop_o[t]),
         .pop_i   (ej_pop[t]),
         .wdata_i (data_out_i[t*PS +: PS]),
         .rdata_o (ej_rd[t]),
         .full_o  (ej_full[t]),
         .empty_o (ej_empty[t])
      );

      assign dest = data_out_i[t*PS + DM -: DEST_W];
      assign mis_hit[t] = pop_o[t]
                       && (dest != term_id(t, ROWS, COLUMNS))
                       && (dest != BDCST);
   end

   assign ovf_set = host_wr_i & host_full_o & ~popin_i;

   always_comb begin
      inj_inc = '0;
      for (int i = 0; i < N_TERM; i++) begin
         inj_inc += 32'(popin_i[i] && !inj_empty[i]);
      end
   end

   // round-robin search starting at rr_q
   always_comb begin
      int k;
      gnt_v = 1'b0;
      gnt   = '0;
      k     = 0;
      for (int i = 0; i < N_TERM; i++) begin
         k = int'(rr_q) + i;
         if (k >= N_TERM) k = k - N_TERM;
         if (!gnt_v && !ej_empty[k]) begin
            gnt_v = 1'b1;
            gnt   = TW'(k);
         end
      end
   end

   assign load = !ej_valid_q || ej_ready_i;

   always_comb begin
      ej_pop = '0;
      if (load && gnt_v) ej_pop[gnt] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hold_q <= '0;
         run_q  <= 1'b0;
      end else begin
         hold_q <= pop_o;
         run_q  <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ej_valid_q <= 1'b0;
         ej_data_q  <= '0;
         ej_term_q  <= '0;
         rr_q       <= '0;
      end else if (load) begin
         ej_valid_q <= gnt_v;
         if (gnt_v) begin
            ej_data_q <= ej_rd[gnt];
            ej_term_q <= gnt;
            rr_q      <= (gnt == TW'(N_TERM - 1)) ? '0 : gnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         inj_cnt_q <= '0;
         ej_cnt_q  <= '0;
         err_ovf_q <= '0;
         err_mis_q <= '0;
      end else if (clr_i) begin
         inj_cnt_q <= '0;
         ej_cnt_q  <= '0;
         err_ovf_q <= '0;
         err_mis_q <= '0;
      end else begin
         inj_cnt_q <= inj_cnt_q + inj_inc;
         ej_cnt_q  <= ej_cnt_q + 32'(ej_valid_q && ej_ready_i);
         err_ovf_q <= err_ovf_q | ovf_set;
         err_mis_q <= err_mis_q | mis_hit;
      end
   end

   assign ej_valid_o     = ej_valid_q;
   assign ej_data_o      = ej_data_q;
   assign ej_term_o      = ej_term_q;
   assign inj_cnt_o      = inj_cnt_q;
   assign ej_cnt_o       = ej_cnt_q;
   assign err_ovf_o      = err_ovf_q;
   assign err_misroute_o = err_mis_q;

endmodule

// File: tb/tb_mesh_term_bridge.sv
// Scoreboard bench for mesh_term_bridge: random host/router traffic,
// per-terminal reference queues, directed fill/eject/misroute/RR/counter cases.
module tb_mesh_term_bridge;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int PS = 32;
   localparam int FD = 16;
   localparam int N  = 16;
   localparam int TW = 4;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic            clr_i = 1'b0;
   logic [N-1:0]    host_wr_i = '0;
   logic [N*PS-1:0] host_data_i = '0;
   logic [N-1:0]    host_full_o;
   logic [N-1:0]    pndng_i_in_o;
   logic [N*PS-1:0] data_out_i_in_o;
   logic [N-1:0]    popin_i = '0;
   logic [N-1:0]    pndng_i = '0;
   logic [N*PS-1:0] data_out_i = '0;
   logic [N-1:0]    pop_o;
   logic            ej_valid_o;
   logic            ej_ready_i = 1'b0;
   logic [PS-1:0]   ej_data_o;
   logic [TW-1:0]   ej_term_o;
   logic [31:0]     inj_cnt_o;
   logic [31:0]     ej_cnt_o;
   logic [N-1:0]    err_ovf_o;
   logic [N-1:0]    err_misroute_o;

   always #5 clk_i = ~clk_i;

   mesh_term_bridge dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .clr_i           (clr_i),
      .host_wr_i       (host_wr_i),
      .host_data_i     (host_data_i),
      .host_full_o     (host_full_o),
      .pndng_i_in_o    (pndng_i_in_o),
      .data_out_i_in_o (data_out_i_in_o),
      .popin_i         (popin_i),
      .pndng_i         (pndng_i),
      .data_out_i      (data_out_i),
      .pop_o           (pop_o),
      .ej_valid_o      (ej_valid_o),
      .ej_ready_i      (ej_ready_i),
      .ej_data_o       (ej_data_o),
      .ej_term_o       (ej_term_o),
      .inj_cnt_o       (inj_cnt_o),
      .ej_cnt_o        (ej_cnt_o),
      .err_ovf_o       (err_ovf_o),
      .err_misroute_o  (err_misroute_o)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // reference state
   logic [PS-1:0] inj_q  [N][$];
   logic [PS-1:0] rq     [N][$];
   logic [PS-1:0] ej_exp [N][$];
   logic [N-1:0]  ovf_m = '0;
   logic [N-1:0]  mis_m = '0;
   int unsigned   inj_m = 0;
   int unsigned   ej_m  = 0;
   logic [N-1:0]  prev_pop = '0;
   logic          prev_hold = 1'b0;
   logic [PS-1:0] prev_data;
   logic [TW-1:0] prev_term;
   int            term_log[$];

   function automatic logic [7:0] tid(int t);
      int r;
      int c;
      if (t < C)              begin r = 0;         c = t + 1;         end
      else if (t < 2*C)       begin r = R + 1;     c = t - C + 1;     end
      else if (t < 2*C + R)   begin r = t - 2*C + 1; c = 0;           end
      else                    begin r = t - 2*C - R + 1; c = C + 1;   end
      return {r[3:0], c[3:0]};
   endfunction

   function automatic logic [PS-1:0] mkpkt(logic [7:0] d);
      logic [PS-1:0] p;
      p = $urandom;
      p[PS-9 -: 8] = d;
      return p;
   endfunction

   // monitor: compare current state, then advance model for the next edge
   always @(negedge clk_i) begin
      logic [N-1:0] pend;
      logic [N-1:0] full;
      logic [7:0]   d;
      logic [PS-1:0] p;
      if (!rst_i) begin
         for (int t = 0; t < N; t++) begin
            inj_q[t].delete();
            ej_exp[t].delete();
         end
         ovf_m = '0; mis_m = '0; inj_m = 0; ej_m = 0;
         prev_pop = '0; prev_hold = 1'b0;
      end else begin
         for (int t = 0; t < N; t++) begin
            pend[t] = inj_q[t].size() > 0;
            full[t] = inj_q[t].size() == FD;
            if (pend[t])
               chk($sformatf("inj_head%0d", t),
                   data_out_i_in_o[t*PS +: PS], inj_q[t][0]);
         end
         chk("pndng_out", pndng_i_in_o, pend);
         chk("host_full", host_full_o, full);
         chk("err_ovf", err_ovf_o, ovf_m);
         chk("err_misroute", err_misroute_o, mis_m);
         chk("inj_cnt", inj_cnt_o, inj_m);
         chk("ej_cnt", ej_cnt_o, ej_m);
         if (prev_hold) begin
            chk("hold_valid", ej_valid_o, 1);
            chk("hold_data", ej_data_o, prev_data);
            chk("hold_term", ej_term_o, prev_term);
         end
         if (ej_valid_o && ej_ready_i) begin
            if (ej_exp[ej_term_o].size() == 0) begin
               chk("ej_unexpected", ej_term_o, 'hFF);
            end else begin
               p = ej_exp[ej_term_o].pop_front();
               chk("ej_data", ej_data_o, p);
            end
            term_log.push_back(int'(ej_term_o));
            ej_m++;
         end
         for (int t = 0; t < N; t++) begin
            if (pop_o[t]) begin
               chk("pop_pending", pndng_i[t], 1);
               chk("pop_holdoff", prev_pop[t], 0);
               if (rq[t].size() > 0) begin
                  p = rq[t].pop_front();
                  ej_exp[t].push_back(p);
                  d = p[PS-9 -: 8];
                  if (d != tid(t) && d != 8'hFF) mis_m[t] = 1'b1;
               end
            end
            if (popin_i[t] && inj_q[t].size() > 0) begin
               void'(inj_q[t].pop_front());
               inj_m++;
            end
            if (host_wr_i[t]) begin
               if (inj_q[t].size() < FD)
                  inj_q[t].push_back(host_data_i[t*PS +: PS]);
               else
                  ovf_m[t] = 1'b1;
            end
         end
         if (clr_i) begin
            ovf_m = '0; mis_m = '0; inj_m = 0; ej_m = 0;
         end
         prev_pop  = pop_o;
         prev_hold = ej_valid_o && !ej_ready_i;
         prev_data = ej_data_o;
         prev_term = ej_term_o;
      end
   end

   task automatic drive_router();
      for (int t = 0; t < N; t++) begin
         pndng_i[t] = rst_i && (rq[t].size() > 0);
         data_out_i[t*PS +: PS] = (rq[t].size() > 0) ? rq[t][0] : '0;
      end
   endtask

   task automatic step();
      drive_router();
      @(posedge clk_i);
      #1;
      host_wr_i = '0;
      popin_i   = '0;
      clr_i     = 1'b0;
   endtask

   task automatic wr(int t, logic [PS-1:0] d);
      host_wr_i[t] = 1'b1;
      host_data_i[t*PS +: PS] = d;
   endtask

   task automatic chk_rst_outs();
      chk("rst_pndng", pndng_i_in_o, 0);
      chk("rst_pop", pop_o, 0);
      chk("rst_valid", ej_valid_o, 0);
      chk("rst_data", ej_data_o, 0);
      chk("rst_term", ej_term_o, 0);
      chk("rst_cnts", {inj_cnt_o, ej_cnt_o}, 0);
      chk("rst_errs", {err_ovf_o, err_misroute_o}, 0);
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      #1;
      chk_rst_outs();
      for (int t = 0; t < N; t++) rq[t].delete();
      step();
      step();
      rst_i = 1'b1;
      step();
   endtask

   initial begin
      int exp_ord[6];
      bit ok;
      exp_ord = '{1, 4, 9, 1, 4, 9};
      #1;
      chk_rst_outs();
      repeat (2) step();
      rst_i = 1'b1;
      step();

      // fill terminal 3 past capacity, then drain in order
      for (int i = 0; i < 17; i++) begin
         wr(3, $urandom);
         step();
         if (i == 15) chk("fill_full3", host_full_o[3], 1);
      end
      chk("fill_ovf3", err_ovf_o[3], 1);
      for (int i = 0; i < 16; i++) begin
         popin_i[3] = 1'b1;
         step();
      end
      chk("fill_empty3", pndng_i_in_o[3], 0);

      // ejection pacing on terminal 0
      ej_ready_i = 1'b1;
      repeat (3) rq[0].push_back(mkpkt(8'h01));
      for (int c = 0; c < 6; c++) begin
         drive_router();
         @(negedge clk_i);
         chk($sformatf("eject_pop_c%0d", c), pop_o[0], (c % 2) == 0);
         @(posedge clk_i);
         #1;
      end
      repeat (6) step();
      chk("eject_nomis0", err_misroute_o[0], 0);

      // misroute on terminal 5, broadcast on terminal 6
      ej_ready_i = 1'b0;
      rq[5].push_back(mkpkt(8'h22));
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = ej_valid_o;
      end
      chk("mis_wait", ok, 1);
      chk("mis_term5", ej_term_o, 5);
      chk("mis_flag5", err_misroute_o[5], 1);
      ej_ready_i = 1'b1;
      rq[6].push_back(mkpkt(8'hFF));
      repeat (10) step();
      chk("bcast_flag6", err_misroute_o[6], 0);

      // round-robin order
      do_reset();
      term_log.delete();
      for (int k = 0; k < 2; k++) begin
         rq[1].push_back(mkpkt(tid(1)));
         rq[4].push_back(mkpkt(tid(4)));
         rq[9].push_back(mkpkt(tid(9)));
      end
      repeat (12) step();
      chk("rr_count", term_log.size(), 6);
      for (int i = 0; i < 6 && i < term_log.size(); i++)
         chk($sformatf("rr_order%0d", i), term_log[i], exp_ord[i]);

      // counters and clear-wins
      do_reset();
      for (int i = 0; i < 10; i++) begin
         wr(0, $urandom);
         step();
      end
      for (int i = 0; i < 10; i++) begin
         popin_i[0] = 1'b1;
         step();
      end
      repeat (10) rq[2].push_back(mkpkt(tid(2)));
      repeat (30) step();
      chk("cnt_inj10", inj_cnt_o, 10);
      chk("cnt_ej10", ej_cnt_o, 10);
      ej_ready_i = 1'b0;
      rq[2].push_back(mkpkt(tid(2)));
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = ej_valid_o;
      end
      chk("clr_wait", ok, 1);
      ej_ready_i = 1'b1;
      clr_i = 1'b1;
      step();
      chk("clr_inj", inj_cnt_o, 0);
      chk("clr_ej", ej_cnt_o, 0);

      // random traffic with a mid-run reset
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int t = 0; t < N; t++) begin
            if ($urandom_range(0, 3) == 0) wr(t, $urandom);
            popin_i[t] = ($urandom_range(0, 2) == 0);
            if (rq[t].size() < 3 && $urandom_range(0, 5) == 0) begin
               case ($urandom_range(0, 2))
                  0: rq[t].push_back(mkpkt(tid(t)));
                  1: rq[t].push_back(mkpkt(8'hFF));
                  default: rq[t].push_back(mkpkt(8'($urandom)));
               endcase
            end
         end
         ej_ready_i = ($urandom_range(0, 3) != 0);
         clr_i = ($urandom_range(0, 199) == 0);
         step();
         if (cyc == 700) do_reset();
      end

      // drain everything
      ej_ready_i = 1'b1;
      ok = 0;
      for (int i = 0; i < 600 && !ok; i++) begin
         popin_i = '1;
         step();
         ok = !ej_valid_o;
         for (int t = 0; t < N; t++)
            if (rq[t].size() || ej_exp[t].size() || inj_q[t].size())
               ok = 0;
      end
      chk("drain_done", ok, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
